// File: rtl/fetch_unit_if.sv
// Bus bundle for fetch_unit: instruction-memory request/response path, redirect
// input and the decode-side valid/ready output.
interface fetch_unit_if;
  // Handshakes: a request is issued on every cycle imem_req=1 (memory always
  // accepts); each request returns exactly one imem_rvalid pulse, in order.
  // An output transfer happens on a rising edge where out_valid && out_ready;
  // out_pc/out_instr stay stable while out_valid=1 and out_ready=0.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue, redirect flush and
// decode stall. Define FETCH_PERF_EN to add stall_cycles/flush_count counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   flush_count
`endif
);

  localparam int unsigned     PTR_W   = $clog2(DEPTH);
  localparam int unsigned     CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic [31:0]      last_instr_q, last_instr_d;

  logic             empty;
  logic             credit;
  logic             issue;
  logic             push;
  logic             pop;
  logic [31:0]      head_pc;
  logic [31:0]      head_instr;
  logic [31:0]      redirect_base;

  assign empty         = (count_q == '0);
  assign head_pc       = pc_mem_q[rd_ptr_q];
  assign head_instr    = instr_mem_q[rd_ptr_q];
  assign redirect_base = bus.redirect_pc & ~32'h3;

  // Buffered plus in-flight words never exceed DEPTH, so a response always has a slot.
  assign credit = ({1'b0, count_q} + {1'b0, outstanding_q}) < {1'b0, DEPTH_C};
  assign issue  = reset && credit && !bus.redirect;
  assign push   = bus.imem_rvalid && (drop_cnt_q == '0) && !bus.redirect;
  assign pop    = !empty && bus.out_ready && !bus.redirect;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = !empty;
  assign bus.out_pc    = empty ? last_pc_q    : head_pc;
  assign bus.out_instr = empty ? last_instr_q : head_instr;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    last_pc_d     = last_pc_q;
    last_instr_d  = last_instr_q;

    if (!empty) begin
      last_pc_d    = head_pc;
      last_instr_d = head_instr;
    end

    if (bus.redirect) begin
      fetch_pc_d    = redirect_base;
      resp_pc_d     = redirect_base;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      outstanding_d = outstanding_q - CNT_W'(bus.imem_rvalid);
      // Everything still in flight is stale, including words already marked
      // for dropping, so the drop count becomes the in-flight total.
      drop_cnt_d    = outstanding_q - CNT_W'(bus.imem_rvalid);
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
      outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(bus.imem_rvalid);
      if (bus.imem_rvalid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      last_pc_q     <= '0;
      last_instr_q  <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      last_pc_q     <= last_pc_d;
      last_instr_q  <= last_instr_d;
    end
  end

  // Entry contents need no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
      instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (count_q == DEPTH_C)));

`ifdef FETCH_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!empty && !bus.out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
    if (bus.redirect && (flush_q != 32'hFFFF_FFFF)) begin
      flush_d = flush_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule
